// File: rtl/pipe_hazard_tracker_pkg.sv
// Shared definitions for the decode-stage hazard tracker: register ID width,
// forwarding select encodings, the in-flight writer tag, and small helpers.
package pipe_hazard_tracker_pkg;

    localparam int REG_ID_W = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_XM = 2'b01,
        FWD_MW = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                valid;
        logic                write_en;
        logic                mem_read;
        logic [REG_ID_W-1:0] reg_rd;
    } tag_t;

    // A tag only matches when it is a live register writer for that ID.
    function automatic logic tag_match(input tag_t t, input logic [REG_ID_W-1:0] r);
        return t.valid & t.write_en & (t.reg_rd == r);
    endfunction

    // One-hot destination of a live writer, zero otherwise.
    function automatic logic [NUM_REGS-1:0] tag_onehot(input tag_t t);
        logic [NUM_REGS-1:0] one_s;
        one_s = {{(NUM_REGS-1){1'b0}}, 1'b1};
        if (t.valid & t.write_en) begin
            return one_s << t.reg_rd;
        end else begin
            return {NUM_REGS{1'b0}};
        end
    endfunction

    // Forwarding select for one source: youngest live writer wins. A load in
    // X never forwards (the stall keeps the reader in D); anything matching
    // only in W is covered by write-before-read in the register file.
    function automatic fwd_sel_e fwd_select(input logic rd_en,
                                            input logic [REG_ID_W-1:0] r,
                                            input tag_t tx,
                                            input tag_t tm);
        if (!rd_en) begin
            return FWD_RF;
        end else if (tag_match(tx, r)) begin
            return tx.mem_read ? FWD_RF : FWD_XM;
        end else if (tag_match(tm, r)) begin
            return FWD_MW;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/pipe_hazard_tracker_if.sv
// Decode-side bundle: decode instruction fields and pipeline control in,
// stall/forwarding metadata out.
interface pipe_hazard_tracker_if;
    logic        D_valid;
    logic        D_writeEn;
    logic        D_memRead;
    logic [2:0]  D_regRd;
    logic        D_readRs;
    logic        D_readRt;
    logic [2:0]  D_regRs;
    logic [2:0]  D_regRt;
    logic        stall_ext;
    logic        flush;
    logic        stall_D;
    logic [1:0]  fwdSelRs;
    logic [1:0]  fwdSelRt;
    logic [7:0]  pendMask;
    logic [15:0] stallCnt;

    modport master (
        output D_valid, D_writeEn, D_memRead, D_regRd,
        output D_readRs, D_readRt, D_regRs, D_regRt,
        output stall_ext, flush,
        input  stall_D, fwdSelRs, fwdSelRt, pendMask, stallCnt
    );

    modport slave (
        input  D_valid, D_writeEn, D_memRead, D_regRd,
        input  D_readRs, D_readRt, D_regRs, D_regRt,
        input  stall_ext, flush,
        output stall_D, fwdSelRs, fwdSelRt, pendMask, stallCnt
    );
endinterface

// File: rtl/pipe_hazard_tracker_tag_stage.sv
// One pipeline tag flop: holds while frozen, otherwise takes the incoming
// tag or an invalid bubble.
module hazard_tag_stage
    import pipe_hazard_tracker_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic advance_i,
    input  logic load_i,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t tag_q;
    tag_t tag_d;

    // Next tag: hold when frozen, else load or insert a bubble.
    always_comb begin
        tag_d = tag_q;
        if (advance_i) begin
            if (load_i) begin
                tag_d = tag_i;
            end else begin
                tag_d = '0;
            end
        end else begin
            tag_d = tag_q;
        end
    end

    // Tag register, cleared asynchronously to an invalid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_o = tag_q;

endmodule

// File: rtl/pipe_hazard_tracker.sv
// Decode-stage hazard tracker: X/M/W writer tags, load-use stall,
// registered forwarding selects for the instruction in X, pending-write mask
// and a saturating stall-cycle counter.
module pipe_hazard_tracker
    import pipe_hazard_tracker_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_tracker_if.slave hz
);

    tag_t     tag_x_s, tag_m_s, tag_w_s;
    tag_t     d_tag_s;
    logic     advance_s, kill_s, load_x_s, stall_d_s;
    logic     rs_hit_s, rt_hit_s;
    logic     flush_pend_q, flush_pend_d;
    fwd_sel_e fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;
    logic [15:0] cnt_q, cnt_d;

    assign advance_s = ~hz.stall_ext;
    assign kill_s    = hz.flush | flush_pend_q;
    assign d_tag_s   = '{valid: hz.D_valid, write_en: hz.D_writeEn,
                         mem_read: hz.D_memRead, reg_rd: hz.D_regRd};
    assign rs_hit_s  = hz.D_readRs & tag_match(tag_x_s, hz.D_regRs);
    assign rt_hit_s  = hz.D_readRt & tag_match(tag_x_s, hz.D_regRt);
    assign load_x_s  = hz.D_valid & ~stall_d_s & ~kill_s;

    // Load-use stall: a load in X feeding a source read in D; a kill wins.
    always_comb begin
        stall_d_s = 1'b0;
        if (kill_s) begin
            stall_d_s = 1'b0;
        end else if (hz.D_valid & tag_x_s.mem_read) begin
            stall_d_s = rs_hit_s | rt_hit_s;
        end else begin
            stall_d_s = 1'b0;
        end
    end

    hazard_tag_stage u_tag_x (.clk(clk), .rst_n(rst_n), .advance_i(advance_s),
                              .load_i(load_x_s), .tag_i(d_tag_s), .tag_o(tag_x_s));
    hazard_tag_stage u_tag_m (.clk(clk), .rst_n(rst_n), .advance_i(advance_s),
                              .load_i(1'b1), .tag_i(tag_x_s), .tag_o(tag_m_s));
    hazard_tag_stage u_tag_w (.clk(clk), .rst_n(rst_n), .advance_i(advance_s),
                              .load_i(1'b1), .tag_i(tag_m_s), .tag_o(tag_w_s));

    // Next-state for pending flush, forwarding selects and stall counter.
    always_comb begin
        flush_pend_d = flush_pend_q;
        fwd_rs_d     = fwd_rs_q;
        fwd_rt_d     = fwd_rt_q;
        cnt_d        = cnt_q;
        if (advance_s) begin
            // The pending flush has killed D this cycle; drop it.
            flush_pend_d = 1'b0;
            if (load_x_s) begin
                fwd_rs_d = fwd_select(hz.D_readRs, hz.D_regRs, tag_x_s, tag_m_s);
                fwd_rt_d = fwd_select(hz.D_readRt, hz.D_regRt, tag_x_s, tag_m_s);
            end else begin
                fwd_rs_d = FWD_RF;
                fwd_rt_d = FWD_RF;
            end
            if (stall_d_s && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            // Frozen: remember a flush so it still kills D once we move.
            if (hz.flush) begin
                flush_pend_d = 1'b1;
            end else begin
                flush_pend_d = flush_pend_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_q <= 1'b0;
            fwd_rs_q     <= FWD_RF;
            fwd_rt_q     <= FWD_RF;
            cnt_q        <= 16'd0;
        end else begin
            flush_pend_q <= flush_pend_d;
            fwd_rs_q     <= fwd_rs_d;
            fwd_rt_q     <= fwd_rt_d;
            cnt_q        <= cnt_d;
        end
    end

    assign hz.stall_D  = stall_d_s;
    assign hz.fwdSelRs = fwd_rs_q;
    assign hz.fwdSelRt = fwd_rt_q;
    assign hz.pendMask = tag_onehot(tag_x_s) | tag_onehot(tag_m_s) | tag_onehot(tag_w_s);
    assign hz.stallCnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Self-checking bench for pipe_hazard_tracker: directed hazard scenarios
// followed by random traffic, compared against an in-flight list model.
module tb_pipe_hazard_tracker;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_tracker_if hz();
    pipe_hazard_tracker dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));

    int errors = 0;
    int checks = 0;

    // Reference model: in-flight instructions indexed by distance ahead of D
    // (1 = in X, 2 = in M, 3 = in W).
    bit mv[1:3];
    bit mw[1:3];
    bit ml[1:3];
    int mrd[1:3];
    bit m_pend;
    int m_frs, m_frt, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writes(input int d, input int r);
        return mv[d] && mw[d] && (mrd[d] == r);
    endfunction

    // Operand source = distance of the nearest writer, if within two stages.
    function automatic int model_fwd(input bit rd_en, input int r);
        if (!rd_en) return 0;
        for (int d = 1; d <= 2; d++)
            if (writes(d, r)) return d;
        return 0;
    endfunction

    function automatic bit model_stall();
        if (hz.flush || m_pend || !hz.D_valid) return 1'b0;
        if (!(mv[1] && mw[1] && ml[1])) return 1'b0;
        return (hz.D_readRs && hz.D_regRs == mrd[1]) || (hz.D_readRt && hz.D_regRt == mrd[1]);
    endfunction

    function automatic int model_mask();
        int m = 0;
        for (int d = 1; d <= 3; d++)
            if (mv[d] && mw[d]) m = m | (1 << mrd[d]);
        return m;
    endfunction

    task automatic model_reset();
        for (int d = 1; d <= 3; d++) begin
            mv[d] = 1'b0; mw[d] = 1'b0; ml[d] = 1'b0; mrd[d] = 0;
        end
        m_pend = 1'b0; m_frs = 0; m_frt = 0; m_cnt = 0;
    endtask

    task automatic setd(input bit v, input bit we, input bit ld, input int rd,
                        input bit rrs, input int rs, input bit rrt, input int rt);
        hz.D_valid = v; hz.D_writeEn = we; hz.D_memRead = ld; hz.D_regRd = 3'(rd);
        hz.D_readRs = rrs; hz.D_regRs = 3'(rs); hz.D_readRt = rrt; hz.D_regRt = 3'(rt);
    endtask

    task automatic ctl(input bit se, input bit fl);
        hz.stall_ext = se; hz.flush = fl;
    endtask

    task automatic nop();
        setd(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    // Called at a negedge with inputs applied: check, advance model, clock.
    task automatic cycle();
        bit es, kill, ld;
        #1;
        es = model_stall();
        chk("stall_D", 32'(hz.stall_D), 32'(es));
        chk("fwdSelRs", 32'(hz.fwdSelRs), 32'(m_frs));
        chk("fwdSelRt", 32'(hz.fwdSelRt), 32'(m_frt));
        chk("pendMask", 32'(hz.pendMask), 32'(model_mask()));
        chk("stallCnt", 32'(hz.stallCnt), 32'(m_cnt));
        if (!hz.stall_ext) begin
            kill = hz.flush || m_pend;
            ld = hz.D_valid && !es && !kill;
            m_frs = ld ? model_fwd(hz.D_readRs, hz.D_regRs) : 0;
            m_frt = ld ? model_fwd(hz.D_readRt, hz.D_regRt) : 0;
            for (int d = 3; d >= 2; d--) begin
                mv[d] = mv[d-1]; mw[d] = mw[d-1]; ml[d] = ml[d-1]; mrd[d] = mrd[d-1];
            end
            mv[1] = ld; mw[1] = ld && hz.D_writeEn; ml[1] = ld && hz.D_memRead;
            mrd[1] = ld ? int'(hz.D_regRd) : 0;
            if (es && m_cnt < 65535) m_cnt++;
            m_pend = 1'b0;
        end else if (hz.flush) begin
            m_pend = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            setd(($urandom_range(0, 7) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3));
            ctl(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        ctl(1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_stall_D", 32'(hz.stall_D), 32'd0);
        chk("rst_fwdSelRs", 32'(hz.fwdSelRs), 32'd0);
        chk("rst_fwdSelRt", 32'(hz.fwdSelRt), 32'd0);
        chk("rst_pendMask", 32'(hz.pendMask), 32'd0);
        chk("rst_stallCnt", 32'(hz.stallCnt), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Load r3, then add r4,r3,r1 held in D across its one stall cycle.
        setd(1'b1, 1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0); cycle();
        setd(1'b1, 1'b1, 1'b0, 4, 1'b1, 3, 1'b1, 1); cycle(); cycle();
        nop();
        chk("lu_fwdRs", 32'(hz.fwdSelRs), 32'd2);
        chk("lu_cnt", 32'(hz.stallCnt), 32'd1);
        cycle();

        // add r2; sub r5,r2,r2 -> both sources from XM.
        setd(1'b1, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 0); cycle();
        setd(1'b1, 1'b1, 1'b0, 5, 1'b1, 2, 1'b1, 2); cycle();
        nop();
        chk("alu_fwdRs", 32'(hz.fwdSelRs), 32'd1);
        chk("alu_fwdRt", 32'(hz.fwdSelRt), 32'd1);
        cycle();

        // add r2, nop, st r2 -> MW; then three apart -> register file.
        setd(1'b1, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 0); cycle();
        nop(); cycle();
        setd(1'b1, 1'b0, 1'b0, 0, 1'b1, 2, 1'b1, 7); cycle();
        nop();
        chk("st_fwdRs", 32'(hz.fwdSelRs), 32'd2);
        setd(1'b1, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 0); cycle();
        nop(); cycle(); cycle();
        setd(1'b1, 1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 0); cycle();
        nop();
        chk("far_fwdRs", 32'(hz.fwdSelRs), 32'd0);
        cycle();

        // Two writers of r6 ahead, reader in D -> youngest (XM).
        setd(1'b1, 1'b1, 1'b0, 6, 1'b0, 0, 1'b0, 0); cycle(); cycle();
        setd(1'b1, 1'b1, 1'b0, 1, 1'b1, 6, 1'b0, 0); cycle();
        nop();
        chk("young_fwdRs", 32'(hz.fwdSelRs), 32'd1);
        cycle(); cycle(); cycle(); cycle();
        chk("retired_mask", 32'(hz.pendMask), 32'd0);

        // Flush while frozen for three cycles; kill lands on first free cycle.
        setd(1'b1, 1'b1, 1'b0, 5, 1'b0, 0, 1'b0, 0);
        ctl(1'b1, 1'b1); cycle();
        ctl(1'b1, 1'b0); cycle(); cycle();
        ctl(1'b0, 1'b0); cycle();
        nop(); cycle();
        chk("flush_mask", 32'(hz.pendMask), 32'd0);

        // Flush coinciding with a load-use hazard: flush wins.
        setd(1'b1, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0, 0); cycle();
        setd(1'b1, 1'b1, 1'b0, 2, 1'b1, 1, 1'b0, 0);
        ctl(1'b0, 1'b1); cycle();
        ctl(1'b0, 1'b0); nop(); cycle();

        rand_cycles(600);

        // Fill the tags with writers, then pulse reset between clock edges.
        setd(1'b1, 1'b1, 1'b0, 7, 1'b1, 7, 1'b1, 7); ctl(1'b0, 1'b0);
        cycle(); cycle(); cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pendMask", 32'(hz.pendMask), 32'd0);
        chk("arst_fwdSelRs", 32'(hz.fwdSelRs), 32'd0);
        chk("arst_fwdSelRt", 32'(hz.fwdSelRt), 32'd0);
        chk("arst_stallCnt", 32'(hz.stallCnt), 32'd0);
        chk("arst_stall_D", 32'(hz.stall_D), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        rand_cycles(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
